// File: rtl/gan_ctrl_pkg.sv
// Shared types and constants for the GAN frame-control blocks.
package gan_ctrl_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERROR} seq_state_t;
   localparam int FRAME_CNT_W     = 16;
   localparam int DEFAULT_TIMEOUT = 65536;
endpackage

// File: rtl/gen_seq_watchdog.sv
// Per-layer wait counter: saturating count of WAIT cycles with a timeout flag.
module gen_seq_watchdog
   import gan_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;

   // Saturates at all-ones so a stuck engine can never wrap back below LIMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (clr)
         wait_cnt <= '0;
      else if (en && wait_cnt != '1)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout = (wait_cnt == LIMIT);
endmodule

// File: rtl/gen_layer_sequencer.sv
// Frame sequencer for the generator layer engines: start/done handshakes, watchdog, frame count.
// Optional GEN_SEQ_PERF_CNT_EN adds a frame_cycles latency counter output.
module gen_layer_sequencer
   import gan_ctrl_pkg::*;
#(
   parameter int NUM_LAYERS     = 3,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter int IDX_W          = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic [NUM_LAYERS-1:0]  layer_start,
   input  logic [NUM_LAYERS-1:0]  layer_done,
   output logic                   busy,
   output logic [IDX_W-1:0]       active_layer,
   output logic                   done,
   output logic                   error,
   output logic [IDX_W-1:0]       err_layer,
   output logic [FRAME_CNT_W-1:0] frame_count
`ifdef GEN_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]            frame_cycles
`endif
);
   localparam logic [IDX_W-1:0]      LAST   = IDX_W'(NUM_LAYERS - 1);
   localparam logic [NUM_LAYERS-1:0] LS_ONE = {{(NUM_LAYERS-1){1'b0}}, 1'b1};

   seq_state_t       state;
   logic [IDX_W-1:0] idx;
   logic             timeout;

   gen_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state != S_WAIT),
      .en      (state == S_WAIT),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         idx          <= '0;
         layer_start  <= '0;
         busy         <= 1'b0;
         active_layer <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_layer    <= '0;
         frame_count  <= '0;
      end else begin
         layer_start <= '0;
         done        <= 1'b0;
         if (abort) begin
            state        <= S_IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            active_layer <= '0;
            error        <= 1'b0;
            err_layer    <= '0;
         end else begin
            case (state)
               S_IDLE, S_ERROR: if (start) begin
                  state        <= S_LAUNCH;
                  idx          <= '0;
                  layer_start  <= LS_ONE;
                  busy         <= 1'b1;
                  active_layer <= '0;
                  error        <= 1'b0;
                  err_layer    <= '0;
               end
               S_LAUNCH: state <= S_WAIT;
               S_WAIT: begin
                  // A done on the timeout cycle still counts as completion.
                  if (layer_done[idx]) begin
                     if (idx == LAST) begin
                        state       <= S_FINISH;
                        done        <= 1'b1;
                        frame_count <= frame_count + FRAME_CNT_W'(1);
                     end else begin
                        state        <= S_LAUNCH;
                        idx          <= idx + 1'b1;
                        active_layer <= idx + 1'b1;
                        layer_start  <= LS_ONE << (idx + 1'b1);
                     end
                  end else if (timeout) begin
                     state        <= S_ERROR;
                     error        <= 1'b1;
                     err_layer    <= idx;
                     busy         <= 1'b0;
                     active_layer <= '0;
                  end
               end
               S_FINISH: begin
                  state        <= S_IDLE;
                  idx          <= '0;
                  busy         <= 1'b0;
                  active_layer <= '0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef GEN_SEQ_PERF_CNT_EN
   logic [31:0] perf_cnt;
   logic        go, last_hit;

   assign go       = !abort && start && (state == S_IDLE || state == S_ERROR);
   assign last_hit = !abort && state == S_WAIT && layer_done[idx] && idx == LAST;

   // perf_cnt reads 1 in the layer-0 LAUNCH cycle; +1 folds in the FINISH cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt     <= '0;
         frame_cycles <= '0;
      end else begin
         if (go)
            perf_cnt <= 32'd1;
         else if (busy)
            perf_cnt <= perf_cnt + 32'd1;
         if (last_hit)
            frame_cycles <= perf_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_gen_layer_sequencer.sv
// Scoreboard bench: stimulus queues expected start/done/error events, a monitor pops and compares.
module tb_gen_layer_sequencer;
   localparam int NL = 3;
   localparam int TO = 16;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NL-1:0] layer_done = '0;
   logic [NL-1:0] layer_start;
   logic          busy, done, error;
   logic [IW-1:0] active_layer, err_layer;
   logic [15:0]   frame_count;
`ifdef GEN_SEQ_PERF_CNT_EN
   logic [31:0]   frame_cycles;
`endif

   gen_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .IDX_W(IW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .layer_start  (layer_start),
      .layer_done   (layer_done),
      .busy         (busy),
      .active_layer (active_layer),
      .done         (done),
      .error        (error),
      .err_layer    (err_layer),
      .frame_count  (frame_count)
`ifdef GEN_SEQ_PERF_CNT_EN
      ,
      .frame_cycles (frame_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int K_START = 0, K_DONE = 1, K_ERR = 2;
   typedef struct {int kind; int val; int at;} ev_t;
   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int val, input int at);
      ev_t e;
      e.kind = kind; e.val = val; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic got(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event actual=kind%0d/val%0d required=none (cycle %0d)", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind", kind, e.kind);
         chk("ev_val", val, e.val);
         chk("ev_cycle", cyc, e.at);
      end
   endtask

   // Monitor: every start pulse, done pulse and error rise must match the queue head.
   logic err_q = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (layer_start != '0)   got(K_START, int'(layer_start));
         if (done)                got(K_DONE, int'(frame_count));
         if (error && !err_q)     got(K_ERR, int'(err_layer));
      end
      err_q <= error;
   end

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_start(input int c);
      at(c); start = 1'b1;
      at(c + 1); start = 1'b0;
   endtask

   task automatic pulse_done(input int c, input logic [NL-1:0] v);
      at(c); layer_done = v;
      at(c + 1); layer_done = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   int t0;
   initial begin
      // Reset state
      at(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_layer_start", int'(layer_start), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_frame_count", int'(frame_count), 0);
      chk("rst_active_layer", int'(active_layer), 0);
      rst_n = 1'b1;

      // Nominal: done 5/7/4 cycles after each start
      t0 = 6;
      expect_ev(K_START, 1, t0 + 1);
      expect_ev(K_START, 2, t0 + 7);
      expect_ev(K_START, 4, t0 + 15);
      expect_ev(K_DONE, 1, t0 + 20);
      pulse_start(t0);
      pulse_done(t0 + 6, 3'b001);
      chk("nom_active_layer", int'(active_layer), 1);
      pulse_done(t0 + 14, 3'b010);
      pulse_done(t0 + 19, 3'b100);
      chk("nom_busy_finish", int'(busy), 1);
      chk("nom_frame_count", int'(frame_count), 1);
`ifdef GEN_SEQ_PERF_CNT_EN
      chk("nom_frame_cycles", int'(frame_cycles), 20);
`endif
      at(t0 + 21);
      chk("nom_busy_idle", int'(busy), 0);
      chk("nom_active_idle", int'(active_layer), 0);

      // Timeout on layer 1, then restart from ERROR and complete
      t0 = cyc + 2;
      expect_ev(K_START, 1, t0 + 1);
      expect_ev(K_START, 2, t0 + 4);
      expect_ev(K_ERR, 1, t0 + 21);
      expect_ev(K_START, 1, t0 + 23);
      expect_ev(K_START, 2, t0 + 25);
      expect_ev(K_START, 4, t0 + 27);
      expect_ev(K_DONE, 2, t0 + 29);
      pulse_start(t0);
      pulse_done(t0 + 3, 3'b001);
      at(t0 + 20);
      chk("to_error_early", int'(error), 0);
      at(t0 + 22);
      chk("to_error_hold", int'(error), 1);
      chk("to_err_layer", int'(err_layer), 1);
      chk("to_busy_error", int'(busy), 0);
      pulse_start(t0 + 22);
      chk("to_error_cleared", int'(error), 0);
      pulse_done(t0 + 24, 3'b001);
      pulse_done(t0 + 26, 3'b010);
      pulse_done(t0 + 28, 3'b100);
      at(t0 + 30);
      chk("to_busy_end", int'(busy), 0);

      // Abort together with layer_done[1] while waiting on layer 1
      t0 = cyc + 2;
      expect_ev(K_START, 1, t0 + 1);
      expect_ev(K_START, 2, t0 + 3);
      pulse_start(t0);
      pulse_done(t0 + 2, 3'b001);
      at(t0 + 5); abort = 1'b1; layer_done = 3'b010;
      at(t0 + 6); abort = 1'b0; layer_done = '0;
      chk("ab_busy", int'(busy), 0);
      chk("ab_active_layer", int'(active_layer), 0);
      at(t0 + 10);
      chk("ab_frame_count", int'(frame_count), 2);
      chk("ab_busy_later", int'(busy), 0);

      // Spurious done for another layer and start while busy are ignored
      t0 = cyc + 2;
      expect_ev(K_START, 1, t0 + 1);
      expect_ev(K_START, 2, t0 + 7);
      expect_ev(K_START, 4, t0 + 9);
      expect_ev(K_DONE, 3, t0 + 11);
      pulse_start(t0);
      pulse_done(t0 + 3, 3'b100);
      at(t0 + 4); start = 1'b1;
      chk("sp_busy", int'(busy), 1);
      chk("sp_active_layer", int'(active_layer), 0);
      at(t0 + 5); start = 1'b0;
      pulse_done(t0 + 6, 3'b001);
      at(t0 + 8); start = 1'b1; layer_done = 3'b010;
      at(t0 + 9); start = 1'b0; layer_done = '0;
      pulse_done(t0 + 10, 3'b100);
      at(t0 + 14);
      chk("sp_busy_idle", int'(busy), 0);
      chk("sp_frame_count", int'(frame_count), 3);

      // Done on the exact timeout cycle wins
      t0 = cyc + 2;
      expect_ev(K_START, 1, t0 + 1);
      expect_ev(K_START, 2, t0 + 18);
      expect_ev(K_START, 4, t0 + 20);
      expect_ev(K_DONE, 4, t0 + 22);
      pulse_start(t0);
      pulse_done(t0 + 17, 3'b001);
      chk("co_no_error", int'(error), 0);
      pulse_done(t0 + 19, 3'b010);
      pulse_done(t0 + 21, 3'b100);
      at(t0 + 23);
      chk("co_error_end", int'(error), 0);
      chk("co_busy_end", int'(busy), 0);

      // Frame counter wrap from 0xFFFF
      at(cyc + 1);
      force dut.frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count;
      t0 = cyc + 1;
      expect_ev(K_START, 1, t0 + 1);
      expect_ev(K_START, 2, t0 + 3);
      expect_ev(K_START, 4, t0 + 5);
      expect_ev(K_DONE, 0, t0 + 7);
      pulse_start(t0);
      pulse_done(t0 + 2, 3'b001);
      pulse_done(t0 + 4, 3'b010);
      pulse_done(t0 + 6, 3'b100);
`ifdef GEN_SEQ_PERF_CNT_EN
      chk("wr_frame_cycles", int'(frame_cycles), 7);
`endif
      at(t0 + 8);
      chk("wr_frame_count", int'(frame_count), 0);

      at(t0 + 12);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gen_layer_sequencer.md
Name: gen_layer_sequencer

Overview:
- Frame-level controller for the generator pipeline: launches the generator layer engines (layer1, layer2, layer3, …) one after another using their start/done pulse handshakes.
- Tracks which layer is active and guards every layer with a watchdog timeout.
- Reports frame completion, errors and a frame count to the top-level GAN controller.
- Sits between the top-level control and the per-layer MAC engines; it carries no datapath.

Parameters:
- NUM_LAYERS, 3, number of sequenced layer engines (2..8).
- TIMEOUT_CYCLES, 65536, maximum cycles allowed in WAIT for one layer before an error is raised (≥2).
- IDX_W, 3, width of the layer index; must satisfy 2^IDX_W ≥ NUM_LAYERS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE or ERROR.
- abort  in  1  synchronous abort; highest priority.
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse to layer engine i.
- layer_done  in  NUM_LAYERS  one-cycle done pulse from layer engine i.
- busy  out  1  high in LAUNCH/WAIT/FINISH.
- active_layer  out  IDX_W  index of the layer being launched or awaited.
- done  out  1  one-cycle pulse when the final layer completes.
- error  out  1  sticky timeout flag.
- err_layer  out  IDX_W  layer index that timed out.
- frame_count  out  16  completed frames, wraps 0xFFFF→0.

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs 0; idx=0; wait_cnt=0. Reset mid-frame drops the frame with no done pulse.
- All outputs are registered. The FSM has states IDLE, LAUNCH, WAIT, FINISH, ERROR.
- IDLE:
  - start=1 → LAUNCH with idx=0 and wait_cnt cleared.
  - start is ignored in every other state except ERROR.
- LAUNCH (exactly 1 cycle):
  - layer_start[idx]=1, all other bits 0; busy=1.
  - Next state is WAIT.
  - layer_done is ignored in this cycle.
- WAIT:
  - wait_cnt increments each cycle.
  - If layer_done[idx]=1 and idx<NUM_LAYERS-1: idx+1, go to LAUNCH.
  - If layer_done[idx]=1 and idx=NUM_LAYERS-1: go to FINISH.
  - If there is no done and wait_cnt==TIMEOUT_CYCLES-1: go to ERROR, error=1, err_layer=idx.
  - If done and timeout coincide, done wins.
  - layer_done bits for other layers are ignored (spurious).
- FINISH (1 cycle): done=1, frame_count+1, then IDLE. busy drops on entering IDLE.
- ERROR:
  - busy=0; error and err_layer hold.
  - start=1 → clear error and err_layer, relaunch from idx=0 (LAUNCH).
- abort=1 in any state:
  - Next cycle: IDLE, layer_start=0, idx=0, error cleared.
  - No done pulse; frame_count unchanged.
  - abort overrides a simultaneous start or layer_done.
- Latency:
  - start sampled at edge k → layer_start[0] high in cycle k+1.
  - layer_done[i] sampled at edge m → layer_start[i+1] high in cycle m+1.
  - Last layer_done sampled at m → done high in cycle m+1.
- active_layer equals idx while busy, and 0 in IDLE.
- wait_cnt width is clog2(TIMEOUT_CYCLES) and saturates, never wraps.

Optional Feature:
- Macro: GEN_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output frame_cycles (32 bits, reset 0).
  - A free counter runs from the LAUNCH of layer 0 through FINISH.
  - Its value, including the FINISH cycle, is latched into frame_cycles in the same cycle done pulses.
  - Not updated on abort or timeout.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package gan_ctrl_pkg:
  - State enum (IDLE, LAUNCH, WAIT, FINISH, ERROR).
  - FRAME_CNT_W=16.
  - Default TIMEOUT constant.
- One natural sub-module: gen_seq_watchdog, holding the saturating wait counter with clear and enable inputs and a timeout output.

Test Plan:
- Nominal (NUM_LAYERS=3, TIMEOUT_CYCLES=16): start at cycle 0; engines return done 5, 7 and 4 cycles after their starts → layer_start pulses at cycles 1, 7 and 15; done at cycle 20; frame_count=1; busy low from cycle 21.
- Timeout: layer 1 never returns done → error=1 and err_layer=1 exactly 16 WAIT cycles after layer_start[1]; then start → error cleared and layer_start[0] pulses on the next cycle.
- Abort: assert abort together with layer_done[1] while in WAIT for layer 1 → next cycle IDLE, no layer_start[2], no done, frame_count unchanged.
- Spurious/ignored: layer_done[2] during WAIT for layer 0 → no state change; start asserted while busy → ignored, only one done results.
- Coincidence and wrap: layer_done on the timeout cycle → no error and advance to the next layer; preload 0xFFFF frames → next done gives frame_count=0.
- With GEN_SEQ_PERF_CNT_EN, the nominal run gives frame_cycles=20.
